// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register with a one-entry skid buffer that catches a word
// arriving while decode is stalled.
module if_id_register
  import fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        deliver,
  input  logic [31:0] deliver_instr,
  input  logic [31:0] deliver_pc4,
  input  logic        stall_D,
  input  logic        flush,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus_four,
  output logic        valid_D,
  output logic        buf_valid
);

  logic [31:0] buf_instr_r;
  logic [31:0] buf_pc4_r;

  // IF/ID and skid buffer update; a buffered word always wins over a bubble
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      instruction  <= NOP_WORD;
      pc_plus_four <= 32'h0000_0000;
      valid_D      <= 1'b0;
      buf_valid    <= 1'b0;
      buf_instr_r  <= NOP_WORD;
      buf_pc4_r    <= 32'h0000_0000;
    end else if (!stall_D) begin
      if (flush) begin
        instruction  <= NOP_WORD;
        pc_plus_four <= 32'h0000_0000;
        valid_D      <= 1'b0;
        buf_valid    <= 1'b0;
      end else if (buf_valid) begin
        instruction  <= buf_instr_r;
        pc_plus_four <= buf_pc4_r;
        valid_D      <= 1'b1;
        buf_valid    <= 1'b0;
      end else if (deliver) begin
        instruction  <= deliver_instr;
        pc_plus_four <= deliver_pc4;
        valid_D      <= 1'b1;
      end else begin
        instruction  <= NOP_WORD;
        pc_plus_four <= 32'h0000_0000;
        valid_D      <= 1'b0;
      end
    end else begin
      if (flush) begin
        buf_valid <= 1'b0;
      end else if (deliver) begin
        buf_instr_r <= deliver_instr;
        buf_pc4_r   <= deliver_pc4;
        buf_valid   <= 1'b1;
      end else begin
        buf_valid <= buf_valid;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding imem
// handshake and feeds decode through the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        jump,
  input  logic [31:0] jump_address,
  input  logic        stall_F,
  input  logic        stall_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus_four,
  output logic        valid_D
);

  fetch_state_t state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  req_pc_r, req_pc_s;
  logic         deliver_s;
  logic         buf_valid_s;

  // State, PC and in-flight address registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r  <= REQ;
      pc_r     <= RESET_PC;
      req_pc_r <= RESET_PC;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      req_pc_r <= req_pc_s;
    end
  end

  // Next state; a jump always redirects pc, and an in-flight response is
  // either dropped now (rvalid) or later in DROP
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    req_pc_s  = req_pc_r;
    deliver_s = 1'b0;
    case (state_r)
      REQ: begin
        if (jump) begin
          pc_s = jump_address;
        end else if (imem_req && imem_gnt) begin
          req_pc_s = pc_r;
          pc_s     = pc_r + 32'd4;
          state_s  = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (jump) begin
            pc_s = jump_address;
          end else begin
            deliver_s = 1'b1;
          end
          state_s = REQ;
        end else if (jump) begin
          pc_s    = jump_address;
          state_s = DROP;
        end else begin
          state_s = WAIT;
        end
      end
      DROP: begin
        if (jump) begin
          pc_s = jump_address;
        end else begin
          pc_s = pc_r;
        end
        if (imem_rvalid) begin
          state_s = REQ;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = REQ;
      end
    endcase
  end

  // Memory-side outputs
  always_comb begin
    imem_addr = pc_r;
    imem_req  = (state_r == REQ) && !stall_F && !buf_valid_s && !jump && reset_n;
  end

  if_id_register u_if_id (
    .clock         (clock),
    .reset_n       (reset_n),
    .deliver       (deliver_s),
    .deliver_instr (imem_rdata),
    .deliver_pc4   (req_pc_r + 32'd4),
    .stall_D       (stall_D),
    .flush         (jump),
    .instruction   (instruction),
    .pc_plus_four  (pc_plus_four),
    .valid_D       (valid_D),
    .buf_valid     (buf_valid_s)
  );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly upstream of decode. It owns the PC and issues requests to instruction memory over a split request/response interface with one request outstanding. It feeds decode through an IF/ID register with a one-entry skid buffer, and accepts jump/branch redirects resolved in decode. Jumps are not delay-slotted: the fetch following a taken jump is squashed.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset (MIPS text base).
NOP_WORD, 32'h0000_0000, bubble instruction driven to decode (sll $0,$0,0).

Ports:
clock  in  1  pipeline clock; all state updates on rising edge
reset_n  in  1  synchronous, active-low reset
jump  in  1  redirect request from decode (taken jump/branch/jr)
jump_address  in  32  redirect target, valid when jump=1
stall_F  in  1  hazard unit: do not issue a new fetch request
stall_D  in  1  hazard unit: hold IF/ID contents
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, stable while imem_req=1 and not granted
imem_gnt  in  1  memory accepts request (handshake = imem_req & imem_gnt)
imem_rvalid  in  1  response valid, at least 1 cycle after grant
imem_rdata  in  32  instruction word, valid with imem_rvalid
instruction  out  32  IF/ID instruction to decode
pc_plus_four  out  32  IF/ID fetched address + 4 to decode
valid_D  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (reset_n=0 at edge): pc=RESET_PC; state=REQ; buffer empty; instruction=NOP_WORD; pc_plus_four=0; valid_D=0. imem_req is forced 0 while reset_n=0. The memory shares reset_n, so no stale response exists after reset. Reset mid-transaction abandons the transaction.
- imem_addr = pc; imem_req = (state==REQ) & ~stall_F & ~buf_valid & ~jump & reset_n.
- FSM states: REQ, WAIT, DROP.
  - REQ: on grant, capture req_pc=pc, set pc=pc+4, go to WAIT. If jump=1 (req is masked), set pc=jump_address and stay in REQ.
  - WAIT: on rvalid with jump=0, deliver {imem_rdata, req_pc+4} to IF/ID or the buffer, then go to REQ. On rvalid with jump=1, discard the response, set pc=jump_address, go to REQ. On jump without rvalid, set pc=jump_address and go to DROP.
  - DROP: discard the next rvalid, then go to REQ. A further jump in DROP overwrites pc only.
- Delivery when stall_D=0: IF/ID loads the delivered word with valid_D=1.
- Delivery when stall_D=1: the word goes to the skid buffer (buf_valid=1). IF/ID is unchanged.
- IF/ID update priority when stall_D=0: jump → bubble (NOP_WORD, valid_D=0, buffer cleared). Otherwise buf_valid → load from buffer and clear it. Otherwise delivery → load the word. Otherwise → bubble.
- jump with stall_D=1: IF/ID is held, and the buffer is cleared. The hazard unit never asserts jump and stall_D together for the same decode instruction.
- pc wraps modulo 2^32. pc[1:0] is not checked.
- Throughput: 1 instruction per 2 cycles minimum (REQ→WAIT→REQ) with single-cycle memory.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {REQ, WAIT, DROP}
  - NOP_WORD
  - default RESET_PC
- One sub-module: if_id_register. It contains the IF/ID register and the skid buffer, with inputs deliver, deliver_instr, deliver_pc4, stall_D, flush (=jump).
- FSM and PC stay in fetch_stage.

Test Plan:
- Reset, then imem_gnt=1 and rvalid 1 cycle after grant returning 32'h2008_0005 → imem_addr=32'h0040_0000; next delivery gives instruction=32'h2008_0005, pc_plus_four=32'h0040_0004, valid_D=1. Second request goes to 32'h0040_0004.
- Memory holds gnt=0 for 3 cycles → imem_req stays 1 and imem_addr stays 32'h0040_0000; valid_D stays 0 until rvalid.
- jump=1, jump_address=32'h0040_0100 during WAIT (no rvalid) → DROP. The next rvalid word is not delivered (valid_D=0); the next request address is 32'h0040_0100.
- stall_D=1 when rvalid delivers 32'hAAAA_0001 → IF/ID unchanged, buf_valid=1, imem_req=0. Release stall_D → instruction=32'hAAAA_0001, then requests resume.
- jump and rvalid in the same cycle in WAIT → response dropped, IF/ID gets a bubble, and the next imem_addr equals jump_address.
- reset_n=0 in WAIT after grant → next cycle imem_req=0 and valid_D=0. After release, the first request goes to 32'h0040_0000.
